// File: rtl/expr_tx.sv
// Serialises a latched BCD expression (digit (op digit)*) as ASCII bytes over
// a valid/ready handshake, with done/err status pulses.
module expr_tx (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [3:0]  terms,
    input  logic [31:0] digits,
    input  logic [6:0]  ops,
    input  logic        ready,
    output logic [7:0]  out,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, DIGIT, OP, FIN} state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [3:0]  terms_q;
    logic [31:0] digits_q;
    logic [6:0]  ops_q;
    logic [7:0]  out_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [2:0]  idx_d;
    logic        lastTerm;
    logic        termsLegal;
    logic [3:0]  nextNibble;
    logic [3:0]  firstNibble;

    function automatic logic [7:0] digitChar(input logic [3:0] nib);
        return (nib > 4'd9) ? 8'h39 : (8'h30 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] opChar(input logic isMul);
        return isMul ? 8'h2A : 8'h2B;
    endfunction

    always_comb begin
        idx_d       = idx_q + 3'd1;
        lastTerm    = ({1'b0, idx_q} == (terms_q - 4'd1));
        termsLegal  = (terms != 4'd0) && (terms <= 4'd8);
        nextNibble  = digits_q[{idx_q, 2'b00} +: 4];
        firstNibble = digits[3:0];
    end

    // Outputs are registered and updated together with the state they belong to,
    // so out/valid simply hold whenever no byte is accepted.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            terms_q  <= 4'd0;
            digits_q <= 32'd0;
            ops_q    <= 7'd0;
            out_q    <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (termsLegal) begin
                            terms_q  <= terms;
                            digits_q <= digits;
                            ops_q    <= ops;
                            idx_q    <= 3'd0;
                            out_q    <= digitChar(firstNibble);
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= DIGIT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DIGIT: begin
                    if (ready) begin
                        if (lastTerm) begin
                            out_q   <= 8'h00;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            out_q   <= opChar(ops_q[idx_q]);
                            idx_q   <= idx_d;
                            state_q <= OP;
                        end
                    end
                end
                OP: begin
                    if (ready) begin
                        out_q   <= digitChar(nextNibble);
                        state_q <= DIGIT;
                    end
                end
                FIN: begin
                    idx_q   <= 3'd0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_expr_tx.sv
// Self-checking bench for expr_tx: table-driven vectors, hand-written corner
// sequences and randomized expressions checked against a byte-stream model.
module tb_expr_tx;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [3:0]  terms;
    logic [31:0] digits;
    logic [6:0]  ops;
    logic        ready;
    logic [7:0]  out;
    logic        valid;
    logic        busy;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    int         cycles;

    typedef struct {
        logic [3:0]  t;
        logic [31:0] d;
        logic [6:0]  o;
        int          readyPct;
        bit          expErr;
        int          expLen;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    expr_tx dut (
        .clk(clk),
        .clr(clr),
        .start(start),
        .terms(terms),
        .digits(digits),
        .ops(ops),
        .ready(ready),
        .out(out),
        .valid(valid),
        .busy(busy),
        .done(done),
        .err(err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Expected byte stream built directly from the operand/operator lists.
    task automatic buildModel(input int n, input logic [31:0] d, input logic [6:0] o);
        int v;
        expQ.delete();
        for (int k = 0; k < n; k++) begin
            v = int'((d >> (4 * k)) & 32'hF);
            if (v > 9) v = 9;
            expQ.push_back(8'(48 + v));
            if (k < n - 1) expQ.push_back(o[k] ? 8'h2A : 8'h2B);
        end
    endtask

    function automatic bit isDigit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    task automatic applyStimulus(input logic [3:0] t, input logic [31:0] d, input logic [6:0] o, input int readyPct);
        bit         timeout = 0;
        bit         rdy;
        bit         expectDigit = 1;
        bit         bad = 0;
        bit         acc = 0;
        logic [7:0] held;
        logic [7:0] b;
        buildModel(int'(t), d, o);
        gotQ.delete();
        cycles = 0;
        start  = 1'b1;
        terms  = t;
        digits = d;
        ops    = o;
        ready  = 1'b0;
        @(posedge clk); #1;
        start  = 1'($urandom_range(1, 0));
        terms  = 4'($urandom);
        digits = $urandom;
        ops    = 7'($urandom);
        while (gotQ.size() < expQ.size()) begin
            if (cycles >= 400) begin
                timeout = 1;
                break;
            end
            checkOutput("busy_during", 32'(busy), 32'd1);
            checkOutput("valid_during", 32'(valid), 32'd1);
            ready = ($urandom_range(99, 0) < readyPct);
            rdy   = ready;
            held  = out;
            @(posedge clk); #1;
            cycles++;
            if (gotQ.size() + 1 == expQ.size() && rdy) start = 1'b0;
            if (rdy) begin
                b = held;
                gotQ.push_back(b);
                if (isDigit(b)) begin
                    if (!expectDigit) bad = 1;
                    expectDigit = 0;
                    acc = !bad;
                    checkOutput("recog_digit", 32'(acc), 32'd1);
                end else if (b == 8'h2A || b == 8'h2B) begin
                    if (expectDigit) bad = 1;
                    expectDigit = 1;
                    acc = 0;
                end else begin
                    bad = 1;
                    acc = 0;
                end
            end else begin
                checkOutput("hold_out", 32'(out), 32'(held));
            end
        end
        start = 1'b0;
        ready = 1'b0;
        checkOutput("timeout", 32'(timeout), 32'd0);
        checkOutput("stream_len", 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("byte%0d", i), 32'(gotQ[i]), 32'(expQ[i]));
        checkOutput("done_hi", 32'(done), 32'd1);
        checkOutput("fin_valid", 32'(valid), 32'd0);
        checkOutput("fin_busy", 32'(busy), 32'd0);
        checkOutput("fin_out", 32'(out), 32'd0);
        checkOutput("recog_end", 32'(acc), 32'd1);
        @(posedge clk); #1;
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_valid", 32'(valid), 32'd0);
    endtask

    task automatic applyBadStart(input logic [3:0] t);
        start = 1'b1;
        terms = t;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("err_hi", 32'(err), 32'd1);
        checkOutput("err_valid", 32'(valid), 32'd0);
        checkOutput("err_busy", 32'(busy), 32'd0);
        checkOutput("err_out", 32'(out), 32'd0);
        @(posedge clk); #1;
        checkOutput("err_pulse", 32'(err), 32'd0);
        checkOutput("err_valid2", 32'(valid), 32'd0);
        checkOutput("err_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        string ref029;
        tbl[0] = '{4'd3,  32'h00000721, 7'b0000010, 100, 1'b0, 5};
        tbl[1] = '{4'd1,  32'h0000000C, 7'b0000000, 100, 1'b0, 1};
        tbl[2] = '{4'd0,  32'h00000123, 7'b0000000, 100, 1'b1, 0};
        tbl[3] = '{4'd9,  32'h00000123, 7'b0000000, 100, 1'b1, 0};
        tbl[4] = '{4'd8,  32'h98765432, 7'b1010101, 60,  1'b0, 15};
        tbl[5] = '{4'd15, 32'h00000000, 7'b0000000, 100, 1'b1, 0};
        tbl[6] = '{4'd4,  32'hFEDCBA10, 7'b1111111, 50,  1'b0, 7};

        clr = 1'b1; start = 1'b0; terms = 4'd0; digits = 32'd0; ops = 7'd0; ready = 1'b0;
        #1;
        checkOutput("rst_out", 32'(out), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].expErr) begin
                applyBadStart(tbl[i].t);
            end else begin
                applyStimulus(tbl[i].t, tbl[i].d, tbl[i].o, tbl[i].readyPct);
                checkOutput($sformatf("tbl%0d_len", i), 32'(gotQ.size()), 32'(tbl[i].expLen));
            end
        end

        ref029 = "1+2*7";
        applyStimulus(4'd3, 32'h00000721, 7'b0000010, 100);
        checkOutput("r029_cycles", 32'(cycles), 32'd5);
        for (int i = 0; i < 5 && i < gotQ.size(); i++)
            checkOutput($sformatf("r029_byte%0d", i), 32'(gotQ[i]), 32'(ref029[i]));

        applyStimulus(4'd1, 32'h0000000C, 7'b1111111, 100);
        checkOutput("r030_len", 32'(gotQ.size()), 32'd1);
        if (gotQ.size() > 0) checkOutput("r030_nine", 32'(gotQ[0]), 32'h39);

        // Ready stall on the operator byte.
        start = 1'b1; terms = 4'd2; digits = 32'h00000054; ops = 7'd0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("r031_d0", 32'(out), 32'h34);
        @(posedge clk); #1;
        ready = 1'b0;
        checkOutput("r031_plus0", 32'(out), 32'h2B);
        checkOutput("r031_valid0", 32'(valid), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("r031_plus%0d", i), 32'(out), 32'h2B);
            checkOutput($sformatf("r031_valid%0d", i), 32'(valid), 32'd1);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("r031_d1", 32'(out), 32'h35);
        @(posedge clk); #1;
        ready = 1'b0;
        checkOutput("r031_done", 32'(done), 32'd1);
        @(posedge clk); #1;

        // Asynchronous clear while the third byte of an 8-term expression is offered.
        start = 1'b1; terms = 4'd8; digits = 32'h87654321; ops = 7'd0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("r033_third", 32'(out), 32'h32);
        #2 clr = 1'b1;
        #1;
        checkOutput("r033_valid", 32'(valid), 32'd0);
        checkOutput("r033_busy", 32'(busy), 32'd0);
        checkOutput("r033_out", 32'(out), 32'd0);
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput("r033_nodone", 32'(done), 32'd0);
        end
        clr = 1'b0;
        @(posedge clk); #1;
        checkOutput("r033_idle", 32'(valid), 32'd0);
        applyStimulus(4'd2, 32'h00000039, 7'b0000001, 70);
        checkOutput("r033_len", 32'(gotQ.size()), 32'd3);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'($urandom_range(8, 1)), $urandom, 7'($urandom), int'($urandom_range(100, 30)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
